// File: rtl/btn_pkg.sv
// Shared button definitions: FSM state encodings and event codes used by the
// debouncer, the event decoder and any other button consumers.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_2ND  = 3'd3,
        PRESSED2  = 3'd4
    } btn_state_t;

    // 00 is reserved so a valid event can never carry an all-zero code
    typedef enum logic [1:0] {
        EV_NONE   = 2'b00,
        EV_SHORT  = 2'b01,
        EV_LONG   = 2'b10,
        EV_DOUBLE = 2'b11
    } btn_ev_t;

endpackage

// File: rtl/button_event_decoder_if.sv
// Valid/ready event channel from the button decoder to application logic,
// plus the sticky dropped-event flag.
interface button_event_decoder_if;

    logic       ev_valid;
    logic [1:0] ev_code;
    logic       ev_ready;
    logic       ev_ovf;

    modport master (output ev_valid, output ev_code, output ev_ovf, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_ovf, output ev_ready);

endinterface

// File: rtl/btn_event_reg.sv
// Single-entry valid/ready output register with sticky overflow; it knows
// nothing about the FSM, only load requests and the consumer handshake.
module btn_event_reg
    import btn_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  btn_ev_t load_code,
    button_event_decoder_if.master ev_if
);

    // A stalled event is never overwritten; a load that cannot land is
    // recorded in ev_ovf, which only reset clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_if.ev_valid <= 1'b0;
            ev_if.ev_code  <= 2'b00;
            ev_if.ev_ovf   <= 1'b0;
        end else if (ev_if.ev_valid && !ev_if.ev_ready) begin
            if (load) begin
                ev_if.ev_ovf <= 1'b1;
            end
        end else begin
            ev_if.ev_valid <= load;
            if (load) begin
                ev_if.ev_code <= load_code;
            end
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into SHORT/LONG/DOUBLE events and
// emits raw press/release strobes. Double-click detection needs BTN_DCLICK_EN.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DCLICK_CYCLES = 15_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_lvl,
    output logic press_p,
    output logic release_p,
    button_event_decoder_if.master ev_if
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_DCLICK_EN
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
`endif

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_q;
    logic             rise;
    logic             fall;
    logic             ev_load;
    btn_ev_t          ev_load_code;

    assign rise = btn_lvl & ~btn_q;
    assign fall = ~btn_lvl & btn_q;

    // Event requests are decoded from the current state so the event
    // register loads on the same edge as the matching FSM transition.
    always_comb begin
        ev_load      = 1'b0;
        ev_load_code = EV_SHORT;
        case (state)
            PRESSED: begin
                if (fall) begin
`ifndef BTN_DCLICK_EN
                    ev_load      = 1'b1;
                    ev_load_code = EV_SHORT;
`endif
                end else if (cnt == LONG_LAST) begin
                    ev_load      = 1'b1;
                    ev_load_code = EV_LONG;
                end
            end
`ifdef BTN_DCLICK_EN
            WAIT_2ND: begin
                if (!rise && (cnt == DCLICK_LAST)) begin
                    ev_load      = 1'b1;
                    ev_load_code = EV_SHORT;
                end
            end
            PRESSED2: begin
                if (fall) begin
                    ev_load      = 1'b1;
                    ev_load_code = EV_DOUBLE;
                end
            end
`endif
            default: ;
        endcase
    end

    // One shared counter times every state; it restarts on each transition
    // and saturates so a long idle never wraps into a false match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_q     <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
        end else begin
            btn_q     <= btn_lvl;
            press_p   <= rise;
            release_p <= fall;
            cnt       <= (&cnt) ? cnt : cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end
                end
                PRESSED: begin
                    if (fall) begin
`ifdef BTN_DCLICK_EN
                        state <= WAIT_2ND;
`else
                        state <= IDLE;
`endif
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state <= LONG_HELD;
                        cnt   <= '0;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
`ifdef BTN_DCLICK_EN
                WAIT_2ND: begin
                    if (rise) begin
                        state <= PRESSED2;
                        cnt   <= '0;
                    end else if (cnt == DCLICK_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                PRESSED2: begin
                    if (fall) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    btn_event_reg u_event_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ev_load),
        .load_code (ev_load_code),
        .ev_if     (ev_if)
    );

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed self-checking bench for button_event_decoder with LONG_CYCLES=20,
// DCLICK_CYCLES=8; expectations follow whether BTN_DCLICK_EN is defined.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_lvl;
    logic press_p;
    logic release_p;

    button_event_decoder_if ev_if ();

    button_event_decoder #(
        .LONG_CYCLES   (20),
        .DCLICK_CYCLES (8),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_lvl   (btn_lvl),
        .press_p   (press_p),
        .release_p (release_p),
        .ev_if     (ev_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int evCount, shortCount, longCount, doubleCount;
    int pressCount, releaseCount, coincideCount;
    int n;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCounts();
        evCount = 0; shortCount = 0; longCount = 0; doubleCount = 0;
        pressCount = 0; releaseCount = 0; coincideCount = 0;
    endtask

    // Hold btn_lvl for a number of cycles, tallying strobes and accepted events
    task automatic applyStimulus(input logic lvl, input int cycles);
        btn_lvl = lvl;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (press_p) pressCount++;
            if (release_p) releaseCount++;
            if (ev_if.ev_valid && ev_if.ev_ready) begin
                evCount++;
                if (ev_if.ev_code == 2'b01) shortCount++;
                if (ev_if.ev_code == 2'b10) longCount++;
                if (ev_if.ev_code == 2'b11) doubleCount++;
                if (release_p) coincideCount++;
            end
        end
    endtask

    // Cycles until ev_valid rises, or -1 if it never does within the budget
    task automatic waitEvent(input int maxCycles, output int cyclesSeen);
        cyclesSeen = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            tick();
            if (ev_if.ev_valid) begin
                cyclesSeen = i;
                break;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // reset asserted while the button is already held
        rst_n = 1'b0;
        btn_lvl = 1'b1;
        ev_if.ev_ready = 1'b1;
        repeat (3) tick();
        checkOutput("rst_press_p", press_p, 0);
        checkOutput("rst_release_p", release_p, 0);
        checkOutput("rst_ev_valid", ev_if.ev_valid, 0);
        checkOutput("rst_ev_code", ev_if.ev_code, 0);
        checkOutput("rst_ev_ovf", ev_if.ev_ovf, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_fresh_press", press_p, 1);
        waitEvent(40, n);
        checkOutput("long_latency", n, 20);
        checkOutput("long_code", ev_if.ev_code, 2);
        checkOutput("press_one_cycle", press_p, 0);
        tick();
        checkOutput("long_accept", ev_if.ev_valid, 0);
        clearCounts();
        applyStimulus(1'b0, 4);
        checkOutput("long_release_strobe", releaseCount, 1);
        checkOutput("long_release_no_event", evCount, 0);

        // short press: 5 cycles high
        btn_lvl = 1'b1;
        tick();
        checkOutput("short_press_p", press_p, 1);
        applyStimulus(1'b1, 4);
        btn_lvl = 1'b0;
        tick();
        checkOutput("short_release_p", release_p, 1);
`ifdef BTN_DCLICK_EN
        checkOutput("short_not_yet", ev_if.ev_valid, 0);
        waitEvent(20, n);
        checkOutput("short_latency", n, 8);
        checkOutput("short_code", ev_if.ev_code, 1);
`else
        checkOutput("short_valid_now", ev_if.ev_valid, 1);
        checkOutput("short_code", ev_if.ev_code, 1);
`endif
        tick();
        checkOutput("short_one_cycle", ev_if.ev_valid, 0);

        // long press via tallies
        clearCounts();
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, 12);
        checkOutput("lp_presses", pressCount, 1);
        checkOutput("lp_releases", releaseCount, 1);
        checkOutput("lp_events", evCount, 1);
        checkOutput("lp_long", longCount, 1);
        checkOutput("lp_coincide", coincideCount, 0);

        // double tap
        clearCounts();
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 12);
        checkOutput("dt_releases", releaseCount, 2);
`ifdef BTN_DCLICK_EN
        checkOutput("dt_events", evCount, 1);
        checkOutput("dt_double", doubleCount, 1);
        checkOutput("dt_short", shortCount, 0);
        checkOutput("dt_coincide", coincideCount, 1);
`else
        checkOutput("dt_events", evCount, 2);
        checkOutput("dt_short", shortCount, 2);
        checkOutput("dt_double", doubleCount, 0);
        checkOutput("dt_coincide", coincideCount, 2);
`endif

`ifndef BTN_DCLICK_EN
        // new SHORT lands on the same edge the pending LONG is accepted
        ev_if.ev_ready = 1'b0;
        applyStimulus(1'b1, 22);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 3);
        checkOutput("hs_pending_code", ev_if.ev_code, 2);
        btn_lvl = 1'b0;
        ev_if.ev_ready = 1'b1;
        tick();
        checkOutput("hs_valid_kept", ev_if.ev_valid, 1);
        checkOutput("hs_new_code", ev_if.ev_code, 1);
        checkOutput("hs_no_ovf", ev_if.ev_ovf, 0);
        tick();
        checkOutput("hs_drained", ev_if.ev_valid, 0);
`endif

        // overflow: LONG stalled, then a SHORT arrives
        ev_if.ev_ready = 1'b0;
        applyStimulus(1'b1, 22);
        applyStimulus(1'b0, 2);
        checkOutput("ovf_long_valid", ev_if.ev_valid, 1);
        checkOutput("ovf_before", ev_if.ev_ovf, 0);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 12);
        checkOutput("ovf_code_kept", ev_if.ev_code, 2);
        checkOutput("ovf_valid_kept", ev_if.ev_valid, 1);
        checkOutput("ovf_set", ev_if.ev_ovf, 1);
        ev_if.ev_ready = 1'b1;
        tick();
        checkOutput("ovf_drain", ev_if.ev_valid, 0);
        checkOutput("ovf_sticky", ev_if.ev_ovf, 1);

        rst_n = 1'b0;
        tick();
        checkOutput("ovf_reset_clear", ev_if.ev_ovf, 0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
